// File: rtl/enc_pkg.sv
// Shared constants and FSM state type for the streaming 8-to-3 priority encoder.
//   N_IN   : request vector width
//   W_CODE : code width, log2(N_IN)
//   state_t: IDLE (waiting for a vector) / SERVE (draining latched bits)
package enc_pkg;

   localparam int unsigned N_IN   = 8;
   localparam int unsigned W_CODE = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } state_t;

endpackage

// File: rtl/prio_enc_8to3.sv
// Combinational lowest-set-bit encoder; bit 0 has highest priority.
// Ports:
//   vec    : input request vector
//   code_c : index of the lowest set bit of vec (0 when vec is empty)
//   any_c  : vec has at least one bit set
module prio_enc_8to3 #(
   parameter int unsigned N_IN   = enc_pkg::N_IN,
   parameter int unsigned W_CODE = enc_pkg::W_CODE
) (
   input  logic [N_IN-1:0]   vec,
   output logic [W_CODE-1:0] code_c,
   output logic              any_c
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      code_c = '0;
      any_c  = |vec;
      for (int i = int'(N_IN) - 1; i >= 0; i--) begin
         if (vec[i]) code_c = W_CODE'(i);
      end
   end

endmodule

// File: rtl/priority_encoder_8to3_stream.sv
// Streaming priority encoder: latches a request vector, then emits the index
// of each set bit in ascending order, one per code handshake.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   req        : request vector, bit i requests index i
//   req_valid  : req is valid this cycle
//   req_ready  : block can accept a new vector (IDLE only)
//   code       : index of the request currently being served
//   code_valid : code is valid (SERVE)
//   code_ready : downstream accepts code
//   code_last  : current code is the final one of the latched vector
//   busy       : FSM is in SERVE
module priority_encoder_8to3_stream import enc_pkg::*; #(
   parameter int unsigned N_IN   = enc_pkg::N_IN,
   parameter int unsigned W_CODE = enc_pkg::W_CODE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_IN-1:0]   req,
   input  logic              req_valid,
   output logic              req_ready,
   output logic [W_CODE-1:0] code,
   output logic              code_valid,
   input  logic              code_ready,
   output logic              code_last,
   output logic              busy
);

   state_t            state_q, state_n;
   logic [N_IN-1:0]   pending_q, pending_n;
   logic              code_valid_q;
   logic              code_last_q, last_n;
   logic              busy_q;
   logic              req_ready_q;
   logic [W_CODE-1:0] enc_code;
   logic              enc_any;

   // Encoder runs on the registered pending vector only.
   prio_enc_8to3 #(
      .N_IN   (N_IN),
      .W_CODE (W_CODE)
   ) u_enc (
      .vec    (pending_q),
      .code_c (enc_code),
      .any_c  (enc_any)
   );

   // Next-state and next-pending logic.
   always_comb begin
      state_n   = state_q;
      pending_n = pending_q;
      case (state_q)
         IDLE: begin
            // An all-zero vector is consumed but produces nothing.
            if (req_valid && req_ready_q && (req != '0)) begin
               pending_n = req;
               state_n   = SERVE;
            end
         end
         SERVE: begin
            if (code_valid_q && code_ready) begin
               // x & (x-1) drops the lowest set bit, i.e. the one just served.
               pending_n = pending_q & (pending_q - N_IN'(1));
               if (code_last_q) state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      // Exactly one bit left in the next pending vector.
      last_n = (pending_n != '0) && ((pending_n & (pending_n - N_IN'(1))) == '0);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         pending_q    <= '0;
         code_valid_q <= 1'b0;
         code_last_q  <= 1'b0;
         busy_q       <= 1'b0;
         req_ready_q  <= 1'b1;
      end else begin
         state_q      <= state_n;
         pending_q    <= pending_n;
         code_valid_q <= (state_n == SERVE);
         code_last_q  <= last_n;
         busy_q       <= (state_n == SERVE);
         req_ready_q  <= (state_n == IDLE);
      end
   end

   assign req_ready  = req_ready_q;
   assign code_valid = code_valid_q;
   assign code_last  = code_last_q;
   assign busy       = busy_q;
   // pending is empty outside SERVE; gating on any keeps code at zero there.
   assign code       = enc_any ? enc_code : '0;

endmodule

// File: tb/tb_priority_encoder_8to3_stream.sv
// Self-checking bench for priority_encoder_8to3_stream: directed scenarios with
// literal expectations plus randomized traffic against a queue-based model.
module tb_priority_encoder_8to3_stream;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic       req_valid;
   logic       req_ready;
   logic [2:0] code;
   logic       code_valid;
   logic       code_ready;
   logic       code_last;
   logic       busy;

   priority_encoder_8to3_stream dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .code       (code),
      .code_valid (code_valid),
      .code_ready (code_ready),
      .code_last  (code_last),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;
   bit started = 1'b0;

   // Model: indices still owed for the latched vector, in service order.
   int m_q[$];

   // Observed handshakes.
   int log_code[$];
   int log_last[$];
   int log_cyc[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
      else n_pass++;
   endtask

   // Model update and handshake logging on the active edge.
   always @(posedge clk) begin
      cyc++;
      if (!rst && code_valid && code_ready) begin
         log_code.push_back(int'(code));
         log_last.push_back(int'(code_last));
         log_cyc.push_back(cyc);
      end
      if (rst) begin
         started = 1'b1;
         m_q.delete();
      end else if (m_q.size() == 0) begin
         if (req_valid && (req != 8'h00)) begin
            for (int i = 0; i < 8; i++) if (req[i]) m_q.push_back(i);
         end
      end else if (code_ready) begin
         void'(m_q.pop_front());
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (started) begin
         chk("req_ready",  32'(req_ready),  32'(m_q.size() == 0));
         chk("code_valid", 32'(code_valid), 32'(m_q.size() != 0));
         chk("busy",       32'(busy),       32'(m_q.size() != 0));
         chk("code",       32'(code),       (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
         chk("code_last",  32'(code_last),  32'(m_q.size() == 1));
      end
   end

   task automatic clear_log();
      log_code.delete();
      log_last.delete();
      log_cyc.delete();
   endtask

   // codes: nibble i holds the i-th expected code; lasts: bit i is its code_last.
   task automatic chk_log(input string nm, input int n, input logic [31:0] codes, input logic [7:0] lasts);
      chk({nm, "_count"}, 32'(log_code.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
         if (i < log_code.size()) begin
            chk({nm, "_code"}, 32'(log_code[i]), 32'(codes[4*i +: 4]));
            chk({nm, "_last"}, 32'(log_last[i]), 32'(lasts[i]));
         end
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst        = 1'b1;
      req        = 8'h00;
      req_valid  = 1'b1;   // must be ignored while in reset
      code_ready = 1'b0;
      tick(3);
      chk("rst_req_ready",  32'(req_ready),  32'd1);
      chk("rst_code_valid", 32'(code_valid), 32'd0);
      chk("rst_busy",       32'(busy),       32'd0);
      chk("rst_code",       32'(code),       32'd0);
      req_valid = 1'b0;
      rst       = 1'b0;
      tick(2);

      // Single bit.
      clear_log();
      req = 8'b0010_0000; req_valid = 1'b1; code_ready = 1'b1;
      tick(1);
      req_valid = 1'b0; req = 8'h00;
      chk("single_code", 32'(code), 32'd5);
      chk("single_last", 32'(code_last), 32'd1);
      tick(1);
      chk("single_ready2", 32'(req_ready), 32'd1);
      tick(2);
      chk_log("single", 1, 32'h5, 8'b1);

      // Multi-hot, back-to-back codes.
      clear_log();
      req = 8'b1000_1001; req_valid = 1'b1;
      tick(1);
      req_valid = 1'b0;
      tick(4);
      chk_log("multi", 3, 32'h730, 8'b100);
      if (log_cyc.size() == 3) chk("multi_span", 32'(log_cyc[2] - log_cyc[0]), 32'd2);
      else chk("multi_span_present", 32'(log_cyc.size()), 32'd3);

      // Backpressure.
      clear_log();
      code_ready = 1'b0;
      req = 8'b0000_0110; req_valid = 1'b1;
      tick(1);
      req_valid = 1'b0;
      repeat (4) begin
         chk("bp_code_hold", 32'(code), 32'd1);
         chk("bp_last_hold", 32'(code_last), 32'd0);
         tick(1);
      end
      code_ready = 1'b1;
      tick(3);
      chk_log("bp", 2, 32'h21, 8'b10);

      // Zero vector.
      clear_log();
      req = 8'h00; req_valid = 1'b1;
      tick(1);
      chk("zero_code_valid", 32'(code_valid), 32'd0);
      chk("zero_req_ready",  32'(req_ready),  32'd1);
      req_valid = 1'b0;
      tick(1);
      chk("zero_code_valid2", 32'(code_valid), 32'd0);
      chk_log("zero", 0, 32'h0, 8'h0);

      // Reset mid-SERVE after two handshakes.
      clear_log();
      code_ready = 1'b1;
      req = 8'hFF; req_valid = 1'b1;
      tick(1);
      req_valid = 1'b0;
      tick(2);
      rst = 1'b1;
      tick(1);
      chk("midrst_code_valid", 32'(code_valid), 32'd0);
      chk("midrst_busy",       32'(busy),       32'd0);
      chk("midrst_req_ready",  32'(req_ready),  32'd1);
      rst = 1'b0;
      tick(5);
      chk_log("midrst", 2, 32'h10, 8'b00);

      // Full vector under random backpressure.
      clear_log();
      req = 8'hFF; req_valid = 1'b1; code_ready = 1'($urandom_range(0, 1));
      tick(1);
      req_valid = 1'b0;
      for (int k = 0; k < 300 && log_code.size() < 8; k++) begin
         code_ready = 1'($urandom_range(0, 1));
         tick(1);
      end
      code_ready = 1'b1;
      tick(4);
      chk_log("full", 8, 32'h76543210, 8'h80);

      // Randomized traffic; the per-cycle compare does the checking.
      for (int k = 0; k < 3000; k++) begin
         rst        = ($urandom_range(0, 99) == 0);
         req_valid  = 1'($urandom_range(0, 1));
         req        = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         code_ready = ($urandom_range(0, 3) != 0);
         tick(1);
      end
      rst = 1'b0; req_valid = 1'b0; code_ready = 1'b1;
      tick(12);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/priority_encoder_8to3_stream.md
PRIORITY_ENCODER_8TO3_STREAM -- requirements
Module: priority_encoder_8to3_stream

Interface
REQ-001 SHALL have parameter N_IN, default 8: request vector width; only 8 is supported.
REQ-002 SHALL have parameter W_CODE, default 3: code width, equal to log2(N_IN).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port req, input, 8: one-hot or multi-hot request vector; bit i means index i is requested.
REQ-006 SHALL have port req_valid, input, 1: req is valid this cycle.
REQ-007 SHALL have port req_ready, output, 1: block can accept a new vector.
REQ-008 SHALL have port code, output, 3: binary index of the request currently being served.
REQ-009 SHALL have port code_valid, output, 1: code is valid.
REQ-010 SHALL have port code_ready, input, 1: downstream accepts code.
REQ-011 SHALL have port code_last, output, 1: the current code is the final one of the latched vector.
REQ-012 SHALL have port busy, output, 1: high when the FSM is in the SERVE state.

Function
REQ-013 SHALL implement a 2-state FSM: IDLE and SERVE.
REQ-014 SHALL drive req_ready=1 only in IDLE (registered, not dependent on req_valid).
REQ-015 In IDLE, on req_valid&&req_ready with req!=0, SHALL latch req into an internal pending register and enter SERVE at the next edge.
REQ-016 In IDLE, on req_valid&&req_ready with req==0, SHALL discard the vector, stay in IDLE and produce no code.
REQ-017 In SERVE, code SHALL equal the index of the lowest set bit of pending (bit 0 highest priority), so that code 3'b000 maps to bit 0 and code 3'b111 maps to bit 7.
REQ-018 code_valid SHALL be 1 throughout SERVE; the first code appears the cycle after acceptance (1-cycle latency).
REQ-019 code_last SHALL be 1 exactly when pending has a single bit set.
REQ-020 On code_valid&&code_ready, SHALL clear the served bit in pending at the edge; the next lowest set bit is presented the following cycle.
REQ-021 While code_valid&&!code_ready, code, code_last and pending SHALL hold stable.
REQ-022 On the handshake with code_last=1, SHALL return to IDLE; req_ready rises the next cycle (one bubble between vectors, by design).
REQ-023 A vector with k set bits SHALL yield exactly k handshakes, in ascending index order, regardless of backpressure.
REQ-024 code and code_last SHALL be 0 whenever code_valid=0.

Reset
REQ-025 While rst=1 at a clock edge, the block SHALL force state=IDLE, pending=0, code_valid=0, code=0, code_last=0 and busy=0; req_ready SHALL be 1 from the first cycle after reset.
REQ-026 Reset asserted mid-SERVE SHALL abandon remaining pending bits; no further codes are issued for that vector.
REQ-027 A req_valid presented while rst=1 SHALL be ignored.

Structure
REQ-028 Package enc_pkg SHALL hold N_IN, W_CODE and the state typedef enum {IDLE, SERVE}.
REQ-029 Lowest-set-bit encoding SHALL be a combinational sub-module prio_enc_8to3 (in: 8-bit vector; out: 3-bit code, 1-bit any); the top module holds the FSM, the pending register and the handshakes.
REQ-030 All outputs except code (which is taken from prio_enc_8to3 applied to the registered pending) SHALL come directly from registers.

Verification
REQ-031 Single bit: req=8'b0010_0000, code_ready=1 -> one handshake with code=5 and code_last=1; req_ready=1 two cycles after acceptance.
REQ-032 Multi-hot: req=8'b1000_1001, code_ready=1 -> codes 0,3,7 on consecutive cycles; code_last=1 only on 7.
REQ-033 Backpressure: req=8'b0000_0110, code_ready=0 for 4 cycles -> code=1 held stable; then code_ready=1 -> codes 1,2.
REQ-034 Zero vector: req=8'h00, req_valid=1 -> accepted, code_valid stays 0, req_ready stays 1.
REQ-035 Reset mid-SERVE: req=8'hFF, rst=1 after two handshakes -> next cycle code_valid=0, busy=0, req_ready=1; no codes 2..7 are issued.
REQ-036 Full vector: req=8'hFF with random code_ready -> codes 0..7 in order, exactly 8 handshakes.
